scaler_history_fifo: RTL and testbench

//  Downstream consumer of the discriminator scaler. Captures each completed scaler

---
 rtl/scaler_history_fifo_if.sv | 31 +++
 rtl/scaler_history_fifo.sv | 127 ++++++++++++
 tb/tb_scaler_history_fifo.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scaler_history_fifo_if.sv
// Bus between the scaler/readout side and scaler_history_fifo.
// master: scaler + readout logic (drives requests); slave: the history FIFO.
interface scaler_history_fifo_if #(
  parameter int unsigned P_N_WIDTH    = 32,
  parameter int unsigned P_ADDR_WIDTH = 4,
  parameter int unsigned P_TS_WIDTH   = 48,
  parameter int unsigned P_DROP_WIDTH = 16
);
  logic                    update_in;
  logic                    valid_in;
  logic [P_N_WIDTH-1:0]    n_pedge_in;
  logic                    flush;
  logic                    rd_req;
  logic                    rd_valid;
  logic [P_N_WIDTH-1:0]    rd_data;
  logic                    rd_sat;
  logic [P_TS_WIDTH-1:0]   rd_ts;
  logic                    rd_empty_err;
  logic [P_ADDR_WIDTH:0]   fill;
  logic [P_DROP_WIDTH-1:0] n_dropped;

  modport master (
    output update_in, valid_in, n_pedge_in, flush, rd_req,
    input  rd_valid, rd_data, rd_sat, rd_ts, rd_empty_err, fill, n_dropped
  );

  modport slave (
    input  update_in, valid_in, n_pedge_in, flush, rd_req,
    output rd_valid, rd_data, rd_sat, rd_ts, rd_empty_err, fill, n_dropped
  );
endinterface

// File: rtl/scaler_history_fifo.sv
// Circular history buffer of completed scaler periods (count + saturation flag).
// Optional per-entry timestamp enabled by defining SCALER_HIST_TIMESTAMP_EN.
module scaler_history_fifo #(
  parameter int unsigned P_N_WIDTH    = 32,
  parameter int unsigned P_ADDR_WIDTH = 4,
  parameter int unsigned P_TS_WIDTH   = 48,
  parameter int unsigned P_DROP_WIDTH = 16
) (
  input logic                 clk,
  input logic                 i_rst,
  scaler_history_fifo_if.slave bus
);

  localparam int unsigned DEPTH  = 2 ** P_ADDR_WIDTH;
  localparam int unsigned FILL_W = P_ADDR_WIDTH + 1;
`ifdef SCALER_HIST_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = P_N_WIDTH + 1 + P_TS_WIDTH;
`else
  localparam int unsigned ENTRY_W = P_N_WIDTH + 1;
`endif

  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [P_ADDR_WIDTH-1:0] wr_ptr;
  logic [P_ADDR_WIDTH-1:0] rd_ptr;
  logic [FILL_W-1:0]       fill_q;
  logic [P_DROP_WIDTH-1:0] dropped_q;

  logic               empty_c;
  logic               full_c;
  logic               wr_req_c;
  logic               pop_c;
  logic               push_c;
  logic               drop_c;
  logic               sat_c;
  logic [ENTRY_W-1:0] wr_entry_c;
  logic [ENTRY_W-1:0] rd_entry_c;

`ifdef SCALER_HIST_TIMESTAMP_EN
  logic [P_TS_WIDTH-1:0] ts_q;

  // Free-running timestamp, wraps silently; flush does not touch it.
  always_ff @(posedge clk) begin
    if (i_rst) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end
`endif

  // Write/pop qualification; a flush suppresses both, a pop frees a slot for a same-cycle write.
  always_comb begin
    empty_c    = 1'b0;
    full_c     = 1'b0;
    wr_req_c   = 1'b0;
    pop_c      = 1'b0;
    push_c     = 1'b0;
    drop_c     = 1'b0;
    sat_c      = 1'b0;
    wr_entry_c = '0;
    rd_entry_c = mem[rd_ptr];

    empty_c  = (fill_q == '0);
    full_c   = (fill_q == FILL_W'(DEPTH));
    wr_req_c = bus.update_in && bus.valid_in && !bus.flush;
    pop_c    = bus.rd_req && !empty_c && !bus.flush;
    push_c   = wr_req_c && (!full_c || pop_c);
    drop_c   = wr_req_c && full_c && !pop_c;
    sat_c    = &bus.n_pedge_in;
`ifdef SCALER_HIST_TIMESTAMP_EN
    wr_entry_c = {ts_q, sat_c, bus.n_pedge_in};
`else
    wr_entry_c = {sat_c, bus.n_pedge_in};
`endif
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_c && !i_rst) mem[wr_ptr] <= wr_entry_c;
  end

  // Pointers, occupancy, drop counter and registered read port.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fill_q           <= '0;
      dropped_q        <= '0;
      bus.rd_valid     <= 1'b0;
      bus.rd_data      <= '0;
      bus.rd_sat       <= 1'b0;
      bus.rd_empty_err <= 1'b0;
    end else begin
      bus.rd_valid     <= 1'b0;
      bus.rd_empty_err <= 1'b0;
      if (bus.flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        fill_q    <= '0;
        dropped_q <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + 1'b1;
        if (pop_c) begin
          rd_ptr       <= rd_ptr + 1'b1;
          bus.rd_valid <= 1'b1;
          bus.rd_data  <= rd_entry_c[P_N_WIDTH-1:0];
          bus.rd_sat   <= rd_entry_c[P_N_WIDTH];
        end
        if (bus.rd_req && empty_c) bus.rd_empty_err <= 1'b1;
        if (push_c && !pop_c)      fill_q <= fill_q + 1'b1;
        else if (pop_c && !push_c) fill_q <= fill_q - 1'b1;
        if (drop_c && (dropped_q != '1)) dropped_q <= dropped_q + 1'b1;
      end
    end
  end

`ifdef SCALER_HIST_TIMESTAMP_EN
  // Timestamp of the popped entry, updated alongside rd_data.
  always_ff @(posedge clk) begin
    if (i_rst)      bus.rd_ts <= '0;
    else if (pop_c) bus.rd_ts <= rd_entry_c[ENTRY_W-1 -: P_TS_WIDTH];
  end
`else
  assign bus.rd_ts = '0;
`endif

  assign bus.fill      = fill_q;
  assign bus.n_dropped = dropped_q;

endmodule

// File: tb/tb_scaler_history_fifo.sv
// Randomized self-checking bench for scaler_history_fifo against a queue-based model.
module tb_scaler_history_fifo;

  localparam int unsigned N_W   = 32;
  localparam int unsigned A_W   = 4;
  localparam int unsigned TS_W  = 48;
  localparam int unsigned D_W   = 16;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic [N_W-1:0]  data;
    logic            sat;
    logic [TS_W-1:0] ts;
  } ent_t;

  logic clk = 1'b0;
  logic i_rst;

  scaler_history_fifo_if #(.P_N_WIDTH(N_W), .P_ADDR_WIDTH(A_W),
                           .P_TS_WIDTH(TS_W), .P_DROP_WIDTH(D_W)) bus ();

  scaler_history_fifo #(.P_N_WIDTH(N_W), .P_ADDR_WIDTH(A_W),
                        .P_TS_WIDTH(TS_W), .P_DROP_WIDTH(D_W)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  ent_t            q[$];
  logic [D_W-1:0]  exp_drop;
  logic            exp_valid;
  logic            exp_err;
  logic [N_W-1:0]  exp_data;
  logic            exp_sat;
  logic [TS_W-1:0] exp_ts;
  logic [TS_W-1:0] ts_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    check("rd_valid",     64'(bus.rd_valid),     64'(exp_valid));
    check("rd_empty_err", 64'(bus.rd_empty_err), 64'(exp_err));
    check("rd_data",      64'(bus.rd_data),      64'(exp_data));
    check("rd_sat",       64'(bus.rd_sat),       64'(exp_sat));
    check("rd_ts",        64'(bus.rd_ts),        64'(exp_ts));
    check("fill",         64'(bus.fill),         64'(q.size()));
    check("n_dropped",    64'(bus.n_dropped),    64'(exp_drop));
  endtask

  task automatic do_reset();
    i_rst          = 1'b1;
    bus.update_in  = 1'b0;
    bus.valid_in   = 1'b0;
    bus.n_pedge_in = '0;
    bus.flush      = 1'b0;
    bus.rd_req     = 1'b0;
    q.delete();
    exp_drop  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_data  = '0;
    exp_sat   = 1'b0;
    exp_ts    = '0;
    ts_m      = '0;
    @(posedge clk);
    #1;
    check_outputs();
    i_rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model by the pre-edge state, compare after the edge.
  task automatic step(input logic upd, input logic vld, input logic [N_W-1:0] n,
                      input logic fl, input logic rd);
    ent_t e;
    int   size_before;
    bit   pop_ok;
    bus.update_in  = upd;
    bus.valid_in   = vld;
    bus.n_pedge_in = n;
    bus.flush      = fl;
    bus.rd_req     = rd;

    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (fl) begin
      q.delete();
      exp_drop = '0;
    end else begin
      size_before = q.size();
      pop_ok = rd && (size_before != 0);
      if (pop_ok) begin
        e = q.pop_front();
        exp_valid = 1'b1;
        exp_data  = e.data;
        exp_sat   = e.sat;
`ifdef SCALER_HIST_TIMESTAMP_EN
        exp_ts    = e.ts;
`endif
      end
      if (rd && !pop_ok) exp_err = 1'b1;
      if (upd && vld) begin
        if (size_before < DEPTH || pop_ok) begin
          e.data = n;
          e.sat  = (n == {N_W{1'b1}});
          e.ts   = ts_m;
          q.push_back(e);
        end else if (exp_drop != {D_W{1'b1}}) begin
          exp_drop = exp_drop + 1'b1;
        end
      end
    end
    ts_m = ts_m + 1'b1;

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N_W-1:0] rv;
    bit upd, vld, fl, rd;
    int p_upd, p_rd;

    // Scenario 1: three writes, three in-order reads.
    do_reset();
    step(1, 1, 5, 0, 0);
    step(1, 1, 7, 0, 0);
    step(1, 1, 9, 0, 0);
    check("s1_fill3", 64'(bus.fill), 64'd3);
    step(0, 0, 0, 0, 1);
    check("s1_rd0", 64'(bus.rd_data), 64'd5);
    step(0, 0, 0, 0, 1);
    check("s1_rd1", 64'(bus.rd_data), 64'd7);
    step(0, 0, 0, 0, 1);
    check("s1_rd2", 64'(bus.rd_data), 64'd9);
    check("s1_fill0", 64'(bus.fill), 64'd0);
    idle(1);
    check("s1_hold", 64'(bus.rd_data), 64'd9);

    // Scenario 2: overflow by one, drain, then read while empty.
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 1, N_W'(i), 0, 0);
    check("s2_fill", 64'(bus.fill), 64'd16);
    check("s2_drop", 64'(bus.n_dropped), 64'd1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, 1);
      check("s2_rd", 64'(bus.rd_data), 64'(i));
    end
    step(0, 0, 0, 0, 1);
    check("s2_err", 64'(bus.rd_empty_err), 64'd1);
    check("s2_keep", 64'(bus.rd_data), 64'd15);

    // Scenario 3: pop and write together while full.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 1, N_W'(200 + i), 0, 0);
    step(1, 1, 99, 0, 1);
    check("s3_fill", 64'(bus.fill), 64'd16);
    check("s3_drop", 64'(bus.n_dropped), 64'd0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1);
    check("s3_last", 64'(bus.rd_data), 64'd99);

    // Scenario 4: saturation flag and ignored update without valid_in.
    do_reset();
    step(1, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 1, 3, 0, 0);
    step(1, 0, 11, 0, 0);
    check("s4_fill", 64'(bus.fill), 64'd2);
    step(0, 0, 0, 0, 1);
    check("s4_sat1", 64'(bus.rd_sat), 64'd1);
    step(0, 0, 0, 0, 1);
    check("s4_sat0", 64'(bus.rd_sat), 64'd0);

    // Scenario 5: flush beats a same-cycle write; reset clears a partly filled buffer.
    do_reset();
    for (int i = 0; i < 18; i++) step(1, 1, N_W'(i), 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1);
    check("s5_pre_fill", 64'(bus.fill), 64'd5);
    check("s5_pre_drop", 64'(bus.n_dropped), 64'd2);
    step(1, 1, 77, 1, 0);
    check("s5_fill", 64'(bus.fill), 64'd0);
    check("s5_drop", 64'(bus.n_dropped), 64'd0);
    step(0, 0, 0, 0, 1);
    check("s5_err", 64'(bus.rd_empty_err), 64'd1);
    for (int i = 0; i < 4; i++) step(1, 1, N_W'(40 + i), 0, 0);
    step(0, 0, 0, 0, 1);
    do_reset();
    check("s5_rst_fill", 64'(bus.fill), 64'd0);
    check("s5_rst_data", 64'(bus.rd_data), 64'd0);

`ifdef SCALER_HIST_TIMESTAMP_EN
    // Scenario 6: stored timestamp equals the counter in the update cycle.
    do_reset();
    while (ts_m != 100) idle(1);
    step(1, 1, 1, 0, 0);
    while (ts_m != 250) idle(1);
    step(1, 1, 2, 0, 0);
    step(0, 0, 0, 0, 1);
    check("s6_ts100", 64'(bus.rd_ts), 64'd100);
    step(0, 0, 0, 0, 1);
    check("s6_ts250", 64'(bus.rd_ts), 64'd250);
`else
    // Scenario 6: without timestamps rd_ts stays zero.
    do_reset();
    step(1, 1, 5, 0, 0);
    step(0, 0, 0, 0, 1);
    check("s6_data", 64'(bus.rd_data), 64'd5);
    check("s6_ts0", 64'(bus.rd_ts), 64'd0);
`endif

    // Randomized traffic in write-heavy, balanced and read-heavy phases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i < 1000)      begin p_upd = 70; p_rd = 25; end
      else if (i < 2000) begin p_upd = 45; p_rd = 45; end
      else               begin p_upd = 25; p_rd = 70; end
      upd = ($urandom_range(0, 99) < p_upd);
      vld = ($urandom_range(0, 9) != 0);
      rd  = ($urandom_range(0, 99) < p_rd);
      fl  = ($urandom_range(0, 199) == 0);
      if (fl) rd = 1'b0;
      rv  = ($urandom_range(0, 7) == 0) ? {N_W{1'b1}} : N_W'($urandom());
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(upd, vld, rv, fl, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
